dm_write_buffer: RTL
====================

Name: dm_write_buffer

Overview:
- Write-side companion to the read-only instruction cache. It is a FIFO store buffer between the CPU data-memory stage and the slow data memory.
- Accepts word stores from the CPU in one cycle and drains them in order to slow memory using a request/ready handshake.
- Stalls the CPU only when the buffer is full.
- Optionally forwards buffered store data to loads.

Parameters:
DEPTH, 4, number of buffered stores; power of 2, minimum 2
PTR_W, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
wr_en  input  1  CPU store request this cycle
wr_addr  input  32  store byte address; bits [1:0] ignored
wr_data  input  32  store word
stall  output  1  buffer full; store not accepted
empty  output  1  no pending stores; used as store fence
rd_addr  input  32  load address for forwarding lookup
rd_hit  output  1  load address matches a buffered store
rd_data  output  32  forwarded word
mem_wr  output  1  write request to slow memory
mem_addr  output  32  write address, word aligned ({addr[31:2],2'b00})
mem_wdata  output  32  write data
mem_rdy  input  1  slow memory accepted the write; one-cycle pulse

Behaviour:
- Reset is synchronous: when rst_n is low at a rising edge, all of the following take effect on that edge:
  - count, head and tail go to 0; state goes to IDLE.
  - All entry valid bits clear.
  - Outputs: mem_wr=0, mem_addr=0, mem_wdata=0, stall=0, empty=1, rd_hit=0, rd_data=0.
- Reset mid-write drops all pending stores, including the one in flight. A mem_rdy arriving after reset is ignored.
- Storage: DEPTH entries of {addr[31:2], data}, circular, with head (oldest) and tail (next free) pointers of PTR_W bits.
  - Pointers wrap modulo DEPTH.
  - A separate count register of PTR_W+1 bits distinguishes full from empty.
- stall = (count == DEPTH), combinational from registered count. empty = (count == 0).
- Push happens when wr_en && !stall: the entry is written at tail, tail advances, count increments. The entry is visible to drain and forwarding next cycle.
- wr_en while stall is high is ignored. The CPU holds the store and retries.
- Drain FSM:
  - IDLE: mem_wr=0. If count>0, load mem_addr/mem_wdata from the head entry and go to WRITE next cycle.
  - WRITE: mem_wr=1; mem_addr and mem_wdata stay stable until mem_rdy. On mem_rdy, pop head (head+1, count-1) and go to IDLE.
  - This gives one bubble cycle between consecutive writes.
  - mem_rdy in IDLE is ignored.
- Minimum store-to-memory latency: 1 cycle after push to enter WRITE, plus memory latency (ND=3 for the slow memory → 4 cycles to pop).
- Simultaneous push and pop in one cycle: count is unchanged, both pointers advance.
  - When full, the push is still rejected that cycle, because stall is computed from the registered count. The freed slot becomes available the next cycle.
- Store order to memory equals CPU acceptance order. Same-address stores are not coalesced.

Optional Feature:
- DM_WB_FWD_EN defined:
  - rd_hit=1 when any valid entry has addr[31:2]==rd_addr[31:2]. This includes the entry in WRITE until it is popped.
  - rd_data is the data of the youngest matching entry, i.e. closest to tail.
  - Purely combinational; same-cycle wr_en is not forwarded.
- DM_WB_FWD_EN undefined: rd_hit=0 and rd_data=0 constantly, no comparators are built, and the CPU must wait for empty before loads.

Decomposition:
- Shared package/header dm_wb_defs.vh:
  - entry field widths (ENTRY_ADDR_W=30, ENTRY_W=62);
  - FSM state encodings S_IDLE=1'b0, S_WRITE=1'b1;
  - DEPTH/PTR_W defaults.
- One sub-module: dm_wb_fifo, holding storage, pointers and count, with push/pop/head-read ports and exported entry arrays for forwarding. The drain FSM and forwarding logic stay in dm_write_buffer.

Test Plan:
1. Single store: wr_en addr=0x100 data=0xDEADBEEF; mem_rdy pulsed 3 cycles after mem_wr rises → mem_wr=1 with mem_addr=0x100 and mem_wdata=0xDEADBEEF stable throughout; after the pulse, empty=1 and mem_wr=0.
2. Fill: four back-to-back stores 0x0/0x4/0x8/0xC with mem_rdy=0 → stall=1 after the 4th; a 5th store of 0x10 is ignored; memory receives exactly 0x0, 0x4, 0x8, 0xC in order.
3. Full push/pop: full buffer, wr_en 0x20 in the same cycle as mem_rdy → 0x20 rejected (stall=1 that cycle); retried next cycle → accepted, count=4, head and tail wrap correctly.
4. Reset mid-write: two stores pending, mem_wr=1, rst_n=0 for one edge → next cycle mem_wr=0, empty=1, stall=0; a following mem_rdy pulse causes no pop or underflow (empty stays 1).
5. Forwarding (DM_WB_FWD_EN): stores 0x40=0x1, then 0x40=0x2, with mem_rdy=0; rd_addr=0x42 → rd_hit=1, rd_data=0x2; rd_addr=0x44 → rd_hit=0. Without the macro → rd_hit=0.
6. Bubble timing: three stores with mem_rdy asserted in the first WRITE cycle each time → mem_wr pattern 1,0,1,0,1 and empty=1 on the cycle after the third pop.

Source files
------------

// File: rtl/dm_write_buffer_pkg.sv
// Shared definitions for the data-memory write buffer: entry layout, drain states, size defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dm_write_buffer_pkg;

  localparam int DEPTH_DEF    = 4;
  localparam int PTR_W_DEF    = 2;
  localparam int ENTRY_ADDR_W = 30;
  localparam int ENTRY_W      = 62;

  // Drain FSM encoding: one bubble in IDLE between consecutive memory writes.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  // One buffered store: word address (byte address bits [31:2]) plus data.
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [31:0]             data;
  } entry_t;

endpackage

// File: rtl/dm_wb_fifo.sv
// Circular store FIFO: entry storage, head/tail pointers, occupancy count and per-entry valid bits.
// Latency: a pushed entry is visible at head / on the entry ports the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module dm_wb_fifo
  import dm_write_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  entry_t           push_entry_i,
  input  logic             pop_i,
  output entry_t           head_entry_o,
  output logic [PTR_W:0]   count_o,
  output logic [PTR_W-1:0] head_o,
  output entry_t           entries_o [DEPTH],
  output logic [DEPTH-1:0] vld_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // Pointer, count and valid-bit next state; simultaneous push/pop leaves count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (push_i) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + 1'b1;
    end
    if (pop_i) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset drops every pending store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Entry storage needs no reset: valid bits gate every use of its contents.
  always_ff @(posedge clk) begin
    if (rst_n && push_i) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

  assign head_entry_o = mem_q[head_q];
  assign count_o      = count_q;
  assign head_o       = head_q;
  assign entries_o    = mem_q;
  assign vld_o        = vld_q;

endmodule

// File: rtl/dm_write_buffer.sv
// Store buffer between CPU data stage and slow memory; optional load forwarding under DM_WB_FWD_EN.
// Latency: push -> mem_wr one cycle later, held until mem_rdy; one idle bubble between writes.
// Backpressure: stall while full (from registered count); mem_addr/mem_wdata held until mem_rdy.
module dm_write_buffer
  import dm_write_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic        empty,
  input  logic [31:0] rd_addr,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdy
);

  logic             push;
  logic             pop;
  entry_t           push_entry;
  entry_t           head_entry;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] fwd_head;
  entry_t           fwd_entries [DEPTH];
  logic [DEPTH-1:0] fwd_vld;

  state_e                  state_q, state_d;
  logic [ENTRY_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;

  assign stall      = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign push       = wr_en && !stall;
  assign push_entry = '{addr: wr_addr[31:2], data: wr_data};

  dm_wb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_entry_o (head_entry),
    .count_o      (count),
    .head_o       (fwd_head),
    .entries_o    (fwd_entries),
    .vld_o        (fwd_vld)
  );

  // Drain FSM: latch the head entry in IDLE, present it in WRITE until memory accepts.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          mem_addr_d  = head_entry.addr;
          mem_wdata_d = head_entry.data;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_rdy) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drain FSM state and the held memory request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_wr    = (state_q == S_WRITE);
  assign mem_addr  = {mem_addr_q, 2'b00};
  assign mem_wdata = mem_wdata_q;

  // Byte offset of a store never matters: memory is written a word at a time.
  logic unused_wr_lsb;
  assign unused_wr_lsb = ^wr_addr[1:0];

`ifdef DM_WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  logic             unused_rd_lsb;
  assign unused_rd_lsb = ^rd_addr[1:0];

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    fwd_idx = fwd_head;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = fwd_head + PTR_W'(k);
      if (fwd_vld[fwd_idx] && (fwd_entries[fwd_idx].addr == rd_addr[31:2])) begin
        rd_hit  = 1'b1;
        rd_data = fwd_entries[fwd_idx].data;
      end
    end
  end
`else
  logic [DEPTH-1:0] unused_fwd;
  logic             unused_rd;
  assign rd_hit    = 1'b0;
  assign rd_data   = '0;
  assign unused_rd = ^{rd_addr, fwd_head};
  for (genvar g = 0; g < DEPTH; g++) begin : g_unused_fwd
    assign unused_fwd[g] = ^{fwd_entries[g], fwd_vld[g]};
  end
`endif

endmodule
